noc_local_ingress: RTL and testbench

- Router-side endpoint of the NI flit link: receives the 6-flit packets the NI transmits.
- Packet format: header {6'b101111, dest[1:0]}, 4 payload flits MSB first, tail 8'hFF.
- Reassembles and frame-checks each packet, queues it in a small packet queue, then replays it as a flit stream with a routing tag toward the router crossbar/output stage.

---
 rtl/noc_pkg.sv | 40 ++++
 rtl/noc_pkt_fifo.sv | 44 ++++
 rtl/noc_local_ingress.sv | 196 +++++++++++++++++++
 tb/tb_noc_local_ingress.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared constants, state enums and the packet-queue entry type for the
// router-side local ingress port.
package noc_pkg;

  localparam logic [5:0] HDR_MARK      = 6'b101111;
  localparam logic [7:0] TAIL_FLIT     = 8'hFF;
  localparam int         FLITS_PER_PKT = 6;
  localparam int         PAYLOAD_BYTES = FLITS_PER_PKT - 2;

  typedef enum logic [1:0] {
    R_HEAD = 2'd0,
    R_DATA = 2'd1,
    R_TAIL = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_HEAD = 2'd1,
    E_DATA = 2'd2,
    E_TAIL = 2'd3
  } tx_state_t;

  typedef struct packed {
    logic [1:0]  dest;
    logic [31:0] payload;
  } pkt_entry_t;

  function automatic logic [7:0] payload_byte(input logic [31:0] payload,
                                               input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = payload[31:24];
      2'd1:    b = payload[23:16];
      2'd2:    b = payload[15:8];
      default: b = payload[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/noc_pkt_fifo.sv
// Circular packet queue; pointers carry one extra wrap bit so full and empty
// fall out of a pointer compare. Head entry is readable without a pop.
module noc_pkt_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  pkt_entry_t                 push_data,
  input  logic                       pop,
  output pkt_entry_t                 head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  pkt_entry_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/noc_local_ingress.sv
// Router-side endpoint of the NI flit link: reassembles 6-flit packets, queues
// them and replays them with a routing tag. FRAME_CHECK_EN enables header/tail checks.
//
// state  | meaning
// R_HEAD | waiting for a header flit
// R_DATA | collecting the 4 payload bytes, MSB first
// R_TAIL | waiting for the tail; refused while the queue is full
// E_IDLE | queue empty, nothing presented
// E_HEAD | presenting the header of the queue head
// E_DATA | presenting payload bytes of the queue head
// E_TAIL | presenting the tail; its accept pops the entry
module noc_local_ingress
  import noc_pkg::*;
#(
  parameter int         PKT_DEPTH = 2,
  parameter logic [1:0] ROUTER_ID = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] flit_in,
  input  logic       flit_in_valid,
  output logic       flit_in_ready,
  output logic [7:0] out_flit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic [1:0] out_dest,
  output logic       out_local,
  output logic       hdr_err,
  output logic       tail_err,
  output logic [7:0] drop_count
);

  localparam int CW = $clog2(PKT_DEPTH) + 1;

  rx_state_t   rx_state;
  logic [1:0]  rx_cnt;
  logic [1:0]  rx_dest;
  logic [31:0] rx_stage;

  tx_state_t   tx_state;
  logic [1:0]  tx_cnt;

  pkt_entry_t  q_head;
  pkt_entry_t  q_push_data;
  logic        q_full;
  logic        q_empty;
  logic [CW-1:0] q_count;
  logic        q_push;
  logic        q_pop;
  logic        q_more;

  logic        in_acc;
  logic        out_acc;
  logic        hdr_ok;
  logic        tail_ok;
  logic        drop_evt;

`ifdef FRAME_CHECK_EN
  assign hdr_ok  = (flit_in[7:2] == HDR_MARK);
  assign tail_ok = (flit_in == TAIL_FLIT);
`else
  assign hdr_ok  = 1'b1;
  assign tail_ok = 1'b1;
`endif

  // A full queue refuses only the tail; a pop in the same cycle does not bypass.
  assign flit_in_ready = !(rx_state == R_TAIL && q_full);
  assign in_acc        = flit_in_valid && flit_in_ready;

  assign q_push      = in_acc && (rx_state == R_TAIL) && tail_ok;
  assign q_push_data = '{dest: rx_dest, payload: rx_stage};
  assign drop_evt    = in_acc && (((rx_state == R_HEAD) && !hdr_ok) ||
                                  ((rx_state == R_TAIL) && !tail_ok));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= R_HEAD;
      rx_cnt     <= 2'd0;
      rx_dest    <= 2'd0;
      rx_stage   <= 32'd0;
      hdr_err    <= 1'b0;
      tail_err   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      hdr_err  <= 1'b0;
      tail_err <= 1'b0;
      if (in_acc) begin
        case (rx_state)
          R_HEAD: begin
            if (hdr_ok) begin
              rx_dest  <= flit_in[1:0];
              rx_cnt   <= 2'd0;
              rx_state <= R_DATA;
            end else begin
              hdr_err <= 1'b1;
            end
          end
          R_DATA: begin
            rx_stage <= {rx_stage[23:0], flit_in};
            rx_cnt   <= rx_cnt + 2'd1;
            if (rx_cnt == 2'(PAYLOAD_BYTES - 1)) rx_state <= R_TAIL;
          end
          R_TAIL: begin
            if (!tail_ok) tail_err <= 1'b1;
            rx_state <= R_HEAD;
          end
          default: rx_state <= R_HEAD;
        endcase
      end
      if (drop_evt && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

  noc_pkt_fifo #(
    .DEPTH(PKT_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .push_data(q_push_data),
    .pop      (q_pop),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign out_acc = out_valid && out_ready;
  assign q_pop   = out_acc && (tx_state == E_TAIL);
  // Looks ahead at this edge's push so a fresh packet is presented one cycle
  // after its tail, and consecutive packets run back to back.
  assign q_more  = q_push || (q_count > (q_pop ? CW'(1) : CW'(0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= E_IDLE;
      tx_cnt   <= 2'd0;
    end else begin
      case (tx_state)
        E_IDLE: if (q_more) tx_state <= E_HEAD;
        E_HEAD: begin
          if (out_ready) begin
            tx_cnt   <= 2'd0;
            tx_state <= E_DATA;
          end
        end
        E_DATA: begin
          if (out_ready) begin
            tx_cnt <= tx_cnt + 2'd1;
            if (tx_cnt == 2'(PAYLOAD_BYTES - 1)) tx_state <= E_TAIL;
          end
        end
        E_TAIL: if (out_ready) tx_state <= q_more ? E_HEAD : E_IDLE;
        default: tx_state <= E_IDLE;
      endcase
    end
  end

  // Presented flit is decoded from the egress state and the un-popped queue
  // head, so it cannot move while a stalled flit waits for out_ready.
  always_comb begin
    out_flit  = 8'd0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_dest  = 2'd0;
    case (tx_state)
      E_HEAD: begin
        out_flit  = {HDR_MARK, q_head.dest};
        out_valid = 1'b1;
        out_sop   = 1'b1;
        out_dest  = q_head.dest;
      end
      E_DATA: begin
        out_flit  = payload_byte(q_head.payload, tx_cnt);
        out_valid = 1'b1;
        out_dest  = q_head.dest;
      end
      E_TAIL: begin
        out_flit  = TAIL_FLIT;
        out_valid = 1'b1;
        out_eop   = 1'b1;
        out_dest  = q_head.dest;
      end
      default: ;
    endcase
  end

  assign out_local = out_valid && (out_dest == ROUTER_ID);

  logic unused_ok;
  assign unused_ok = q_empty;

endmodule

// File: tb/tb_noc_local_ingress.sv
// Self-checking bench for noc_local_ingress: table vectors, hand sequences for
// stall/reset corners, and randomized traffic against a packet-level model.
module tb_noc_local_ingress;

  localparam int         PKT_DEPTH = 2;
  localparam logic [1:0] ROUTER_ID = 2'b01;
`ifdef FRAME_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] flit_in;
  logic       flit_in_valid;
  logic       flit_in_ready;
  logic [7:0] out_flit;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic [1:0] out_dest;
  logic       out_local;
  logic       hdr_err;
  logic       tail_err;
  logic [7:0] drop_count;

  noc_local_ingress #(
    .PKT_DEPTH(PKT_DEPTH),
    .ROUTER_ID(ROUTER_ID)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_in      (flit_in),
    .flit_in_valid(flit_in_valid),
    .flit_in_ready(flit_in_ready),
    .out_flit     (out_flit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_dest     (out_dest),
    .out_local    (out_local),
    .hdr_err      (hdr_err),
    .tail_err     (tail_err),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  dest;
    logic [31:0] pay;
  } pkt_t;

  // Model: packets committed but not yet fully emitted, plus ingress position.
  pkt_t        m_q[$];
  int          m_pos;
  int          m_opos;
  logic [1:0]  m_dest;
  logic [31:0] m_pay;
  bit          m_hdr_p;
  bit          m_tail_p;
  int          m_drop;

  int          n_total;
  int          n_bad;
  int          dut_pkts;
  bit          last_in_acc;
  bit          prev_stall;
  logic [7:0]  prev_flit;
  logic [7:0]  sq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_flit(input pkt_t p, input int pos);
    logic [31:0] t;
    if (pos == 0) return {6'b101111, p.dest};
    if (pos == 5) return 8'hFF;
    t = p.pay >> (8 * (4 - pos));
    return t[7:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pos      = 0;
    m_opos     = 0;
    m_dest     = 2'd0;
    m_pay      = 32'd0;
    m_hdr_p    = 1'b0;
    m_tail_p   = 1'b0;
    m_drop     = 0;
    prev_stall = 1'b0;
  endtask

  // One clock cycle: compare at mid-low phase, then advance model over the edge.
  task automatic tick();
    bit   m_ready;
    bit   m_ov;
    bit   in_acc;
    bit   out_acc;
    pkt_t hp;
    #1;
    m_ready = !(m_pos == 5 && m_q.size() == PKT_DEPTH);
    m_ov    = (m_q.size() > 0);
    check("flit_in_ready", 32'(flit_in_ready), 32'(m_ready));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("hdr_err", 32'(hdr_err), 32'(m_hdr_p));
    check("tail_err", 32'(tail_err), 32'(m_tail_p));
    check("drop_count", 32'(drop_count), m_drop);
    if (m_ov) begin
      hp = m_q[0];
      check("out_flit", 32'(out_flit), 32'(exp_flit(hp, m_opos)));
      check("out_sop", 32'(out_sop), 32'(m_opos == 0));
      check("out_eop", 32'(out_eop), 32'(m_opos == 5));
      check("out_dest", 32'(out_dest), 32'(hp.dest));
      check("out_local", 32'(out_local), 32'(hp.dest == ROUTER_ID));
    end else begin
      check("idle_sop_eop", 32'({out_sop, out_eop}), 0);
    end
    if (prev_stall) check("stall_hold", 32'(out_flit), 32'(prev_flit));
    if (out_valid && out_ready && out_eop) dut_pkts++;
    prev_stall = out_valid && !out_ready;
    prev_flit  = out_flit;

    in_acc   = flit_in_valid && m_ready;
    out_acc  = m_ov && out_ready;
    m_hdr_p  = 1'b0;
    m_tail_p = 1'b0;
    if (out_acc) begin
      m_opos++;
      if (m_opos == 6) begin
        void'(m_q.pop_front());
        m_opos = 0;
      end
    end
    if (in_acc) begin
      if (m_pos == 0) begin
        if (!CHECK || flit_in[7:2] == 6'b101111) begin
          m_dest = flit_in[1:0];
          m_pos  = 1;
        end else begin
          m_hdr_p = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end else if (m_pos < 5) begin
        m_pay[8*(4-m_pos) +: 8] = flit_in;
        m_pos++;
      end else begin
        if (!CHECK || flit_in == 8'hFF) begin
          m_q.push_back('{dest: m_dest, pay: m_pay});
        end else begin
          m_tail_p = 1'b1;
          if (m_drop < 255) m_drop++;
        end
        m_pos = 0;
      end
    end
    last_in_acc = in_acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    flit_in_valid = 1'b0;
    #1;
    check("reset_outputs",
          32'({flit_in_ready, out_valid, out_sop, out_eop, hdr_err, tail_err,
               out_local, out_flit, out_dest, drop_count}),
          32'h0100_0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // rmode: 0 = hold out_ready, 1 = toggle every cycle, 2 = random
  task automatic apply_ready(input int rmode);
    if (rmode == 1) out_ready = !out_ready;
    else if (rmode == 2) out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic drive(input int max_cycles, input int rmode, input int vpct, output int left);
    int c;
    c = 0;
    while (sq.size() > 0 && c < max_cycles) begin
      flit_in_valid = (vpct >= 100) || ($urandom_range(0, 99) < vpct);
      flit_in       = flit_in_valid ? sq[0] : 8'($urandom);
      apply_ready(rmode);
      tick();
      if (last_in_acc) void'(sq.pop_front());
      c++;
    end
    flit_in_valid = 1'b0;
    left = sq.size();
  endtask

  task automatic drain(input int max_cycles, input int rmode);
    int c;
    c = 0;
    while (m_q.size() > 0 && c < max_cycles) begin
      apply_ready(rmode);
      tick();
      c++;
    end
    check("drain_done", m_q.size(), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic push_pkt(input logic [7:0] hdr, input logic [31:0] pay, input logic [7:0] tail);
    sq.push_back(hdr);
    for (int k = 3; k >= 0; k--) sq.push_back(pay[8*k +: 8]);
    sq.push_back(tail);
  endtask

  typedef struct {
    string       name;
    logic [95:0] bytes;
    int          n;
    int          exp_pkts;
    int          exp_drops;
  } vec_t;

  vec_t vecs[6];
  int   left;
  int   base;

  initial begin
    n_total = 0; n_bad = 0; dut_pkts = 0;
    rst = 1'b1; flit_in = 8'd0; flit_in_valid = 1'b0; out_ready = 1'b1;
    model_reset();

    vecs[0] = '{"single",    96'hBDDEADBEEFFF_000000000000, 6,  1, 0};
    vecs[1] = '{"bad_hdr",   96'h3CBDDEADBEEFFF_0000000000, 7,  1, CHECK ? 1 : 0};
    vecs[2] = '{"bad_tail",  96'hBDDEADBEEFFE_000000000000, 6,  CHECK ? 0 : 1, CHECK ? 1 : 0};
    vecs[3] = '{"dest_10",   96'hBE11223344FF_000000000000, 6,  1, 0};
    vecs[4] = '{"two_pkts",  96'hBC01020304FFBFA0B0C0D0FF, 12, 2, 0};
    vecs[5] = '{"tail_good", 96'hBD0102030400BD05060708FF, 12, CHECK ? 1 : 2, CHECK ? 1 : 0};

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      logic [95:0] v;
      do_reset();
      out_ready = 1'b1;
      v = vecs[i].bytes;
      for (int k = 0; k < vecs[i].n; k++) sq.push_back(v[95-8*k -: 8]);
      base = dut_pkts;
      drive(100, 0, 100, left);
      check({vecs[i].name, "_sent"}, left, 0);
      drain(100, 0);
      check({vecs[i].name, "_pkts"}, dut_pkts - base, vecs[i].exp_pkts);
      check({vecs[i].name, "_drops"}, 32'(drop_count), vecs[i].exp_drops);
    end

    // Three packets into a 2-deep queue with egress stalled.
    do_reset();
    out_ready = 1'b0;
    push_pkt(8'hBD, 32'h11223344, 8'hFF);
    push_pkt(8'hBE, 32'h55667788, 8'hFF);
    push_pkt(8'hBF, 32'h99AABBCC, 8'hFF);
    drive(25, 0, 100, left);
    check("full_tail_pending", left, 1);
    check("full_ready_low", 32'(flit_in_ready), 0);
    base = dut_pkts;
    out_ready = 1'b1;
    drive(60, 0, 100, left);
    check("full_sent", left, 0);
    drain(100, 0);
    check("full_pkts", dut_pkts - base, 3);

    // Egress throttled on alternate cycles.
    do_reset();
    out_ready = 1'b0;
    push_pkt(8'hBC, 32'hCAFEF00D, 8'hFF);
    push_pkt(8'hBD, 32'h0BADBEEF, 8'hFF);
    base = dut_pkts;
    drive(60, 1, 100, left);
    check("toggle_sent", left, 0);
    drain(100, 1);
    check("toggle_pkts", dut_pkts - base, 2);

    // Reset while one packet waits in the queue and another is partial.
    do_reset();
    out_ready = 1'b0;
    push_pkt(8'hBE, 32'h01020304, 8'hFF);
    sq.push_back(8'hBD); sq.push_back(8'hA1); sq.push_back(8'hA2); sq.push_back(8'hA3);
    drive(30, 0, 100, left);
    check("partial_sent", left, 0);
    base = dut_pkts;
    do_reset();
    out_ready = 1'b1;
    push_pkt(8'hBD, 32'hDEADBEEF, 8'hFF);
    drive(30, 0, 100, left);
    drain(60, 0);
    check("after_reset_pkts", dut_pkts - base, 1);

    // Randomized traffic with occasional bad headers and tails.
    do_reset();
    for (int p = 0; p < 200; p++) begin
      logic [7:0] h;
      logic [7:0] t;
      h = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {6'b101111, 2'($urandom)};
      t = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 254)) : 8'hFF;
      push_pkt(h, $urandom, t);
    end
    drive(8000, 2, 75, left);
    check("random_sent", left, 0);
    drain(2000, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
